fetch_queue: RTL and testbench

//  Instruction-fetch front end that sits between the pc register and the IF/ID stage.
//  - Turns each fetch address into an instruction-memory request.
//  - Tags each in-flight request with its pc and buffers in-order responses in a FIFO.
//  - Presents {pc, instruction} to decode with a valid/ready handshake.
//  - Back-pressures the pc via pc_ready. pc_ready=0 acts as the pc stall.
//  - Discards all queued and in-flight fetches on a branch/jump/JALR redirect (flush).

---
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues pc fetches to instruction memory, tags them,
// buffers in-order responses and hands {pc, inst} to decode; flush kills all fetches.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  input  logic            id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]   q_cnt, out_cnt, drop_cnt;
  logic [AW-1:0]   q_head, q_tail, t_head, t_tail;
  logic [XLEN-1:0] q_inst [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] tag_pc [DEPTH];

  logic [CW+1:0] used;
  logic [CW+1:0] flush_drop;
  logic          credit, accept, resp_take, pop;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and pc_ready/id_valid are the pc and decode sides.
  always_comb begin
    used           = (CW+2)'(q_cnt) + (CW+2)'(out_cnt) + (CW+2)'(drop_cnt);
    credit         = used < (CW+2)'(DEPTH);
    imem_req_valid = pc_valid & credit & ~flush & ~rst;
    pc_ready       = imem_req_valid & imem_req_ready;
    accept         = pc_ready;
    resp_take      = imem_resp_valid & (drop_cnt == '0) & (out_cnt != '0);
    pop            = id_valid & id_ready;
    // Every outstanding fetch becomes a drop; a response landing on the flush edge pays one off.
    flush_drop     = (CW+2)'(drop_cnt) + (CW+2)'(out_cnt);
    if (imem_resp_valid && flush_drop != '0)
      flush_drop = flush_drop - (CW+2)'(1);
  end

  assign imem_req_addr = pc_in;
  assign id_valid      = (q_cnt != '0);
  assign id_inst       = q_inst[q_head];
  assign id_pc         = q_pc[q_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      q_cnt    <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
      q_head   <= '0;
      q_tail   <= '0;
      t_head   <= '0;
      t_tail   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
        tag_pc[i] <= '0;
      end
    end else if (flush) begin
      q_cnt    <= '0;
      out_cnt  <= '0;
      drop_cnt <= flush_drop[CW-1:0];
      q_head   <= '0;
      q_tail   <= '0;
      t_head   <= '0;
      t_tail   <= '0;
    end else begin
      if (accept) begin
        tag_pc[t_tail] <= pc_in;
        t_tail         <= t_tail + AW'(1);
      end
      if (resp_take) begin
        q_inst[q_tail] <= imem_resp_data;
        q_pc[q_tail]   <= tag_pc[t_head];
        q_tail         <= q_tail + AW'(1);
        t_head         <= t_head + AW'(1);
      end
      if (pop)
        q_head <= q_head + AW'(1);
      // Responses with nothing pending (e.g. after reset) touch no counter.
      if (imem_resp_valid && drop_cnt != '0)
        drop_cnt <= drop_cnt - CW'(1);
      q_cnt   <= q_cnt + CW'(resp_take) - CW'(pop);
      out_cnt <= out_cnt + CW'(accept) - CW'(resp_take);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory responder, credit/tag reference model,
// scoreboard monitor on the decode handshake, directed scenarios then random traffic.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            pc_valid;
  logic [XLEN-1:0] pc_in;
  logic            pc_ready;
  logic            flush;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid = 1'b0;
  logic [XLEN-1:0] imem_resp_data  = '0;
  logic            id_valid;
  logic [XLEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready),
    .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int held = 0;
  int resp_pct = 0;

  logic [2*XLEN-1:0] exp_q[$];
  logic [XLEN-1:0]   mem_q[$];
  logic [XLEN-1:0]   pend_pc[$];
  bit                pend_live[$];
  logic [XLEN-1:0]   imem[logic [XLEN-1:0]];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory: answers accepted requests strictly in order, with a random gap.
  always @(posedge clk) begin
    logic [XLEN-1:0] a;
    #1;
    if (mem_q.size() > 0 && resp_pct > 0 && $urandom_range(0, 99) < resp_pct) begin
      a = mem_q.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = imem.exists(a) ? imem[a] : $urandom;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  end

  // Reference model: every accepted fetch holds one credit until decode takes it,
  // a flush throws away its queued entry, or its killed response comes back.
  always @(negedge clk) begin
    bit exp_req;
    exp_req = !rst && !flush && pc_valid && (held < DEPTH);
    chk1("req_valid", imem_req_valid, exp_req);
    chk1("pc_ready", pc_ready, exp_req && imem_req_ready);
    if (imem_req_valid) chk("req_addr", imem_req_addr, pc_in);
    if (pc_ready) mem_q.push_back(pc_in);
    if (rst) begin
      held = 0;
      pend_pc.delete();
      pend_live.delete();
      exp_q.delete();
    end else if (flush) begin
      held -= exp_q.size();
      exp_q.delete();
      foreach (pend_live[i]) pend_live[i] = 1'b0;
      if (imem_resp_valid && pend_pc.size() > 0) begin
        void'(pend_pc.pop_front());
        void'(pend_live.pop_front());
        held--;
      end
    end else begin
      if (imem_resp_valid && pend_pc.size() > 0) begin
        if (pend_live[0]) exp_q.push_back({pend_pc[0], imem_resp_data});
        else held--;
        void'(pend_pc.pop_front());
        void'(pend_live.pop_front());
      end
      if (id_valid && id_ready) held--;
      if (exp_req && imem_req_ready) begin
        held++;
        pend_pc.push_back(pc_in);
        pend_live.push_back(1'b1);
      end
    end
  end

  // Monitor: every decode transfer must match the oldest expected entry.
  always @(negedge clk) begin
    logic [2*XLEN-1:0] e;
    if (!rst && !flush && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_id actual pc=%h inst=%h required=no_entry t=%0t", id_pc, id_inst, $time);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e[2*XLEN-1:XLEN]);
        chk("id_inst", id_inst, e[XLEN-1:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pc(input logic [XLEN-1:0] a);
    bit ok = 1'b0;
    cyc();
    pc_valid = 1'b1;
    pc_in    = a;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (pc_ready) ok = 1'b1;
      else cyc();
    end
    chk1("send_pc_accepted", ok, 1'b1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    cyc();
    pc_valid = 1'b0;
    flush    = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    resp_pct = 100;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (mem_q.size() == 0 && exp_q.size() == 0 && !id_valid) done = 1'b1;
    end
    chk1("drain_done", done, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; pc_valid = 1'b1; pc_in = '0; flush = 1'b0;
    imem_req_ready = 1'b1; id_ready = 1'b0;
    imem[32'h0] = 32'h0000_0013;
    imem[32'h4] = 32'h0010_0093;
    imem[32'h8] = 32'h0020_0113;
    imem[32'h100] = 32'hDEAD_BEEF;

    // Reset held two cycles with pc_valid high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_pc_ready", pc_ready, 1'b0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    cyc();
    rst = 1'b0; pc_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    resp_pct = 100;

    // Back-to-back stream; first delivery two cycles after the accept cycle
    send_pc(32'h0);
    send_pc(32'h4);
    chk1("lat_not_yet", id_valid, 1'b0);
    send_pc(32'h8);
    chk1("lat_valid", id_valid, 1'b1);
    chk("lat_pc", id_pc, 32'h0);
    chk("lat_inst", id_inst, 32'h0000_0013);
    drain();

    // Full: four queued, fifth blocked until one pop, credit back the cycle after
    cyc(); id_ready = 1'b0;
    send_pc(32'h0); send_pc(32'h4); send_pc(32'h8); send_pc(32'hC);
    cyc(); pc_in = 32'h10;
    repeat (3) @(negedge clk);
    chk1("full_pc_ready", pc_ready, 1'b0);
    chk1("full_req_valid", imem_req_valid, 1'b0);
    chk1("full_id_valid", id_valid, 1'b1);
    chk("full_id_pc", id_pc, 32'h0);
    cyc(); id_ready = 1'b1;
    @(negedge clk);
    chk1("full_pop_same_cycle", pc_ready, 1'b0);
    cyc(); id_ready = 1'b0;
    @(negedge clk);
    chk1("full_pop_next_cycle", pc_ready, 1'b1);
    drain();

    // Flush with one queued and two outstanding
    cyc(); id_ready = 1'b0;
    send_pc(32'h20);
    cyc(); pc_valid = 1'b0;
    @(negedge clk); resp_pct = 0;
    send_pc(32'h24); send_pc(32'h28);
    cyc(); pc_valid = 1'b1; pc_in = 32'h2C; flush = 1'b1;
    @(negedge clk);
    chk1("flush_no_req", imem_req_valid, 1'b0);
    cyc(); flush = 1'b0; pc_valid = 1'b0;
    @(negedge clk);
    chk1("flush_id_valid", id_valid, 1'b0);
    resp_pct = 100;
    send_pc(32'h100);
    cyc(); pc_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (id_valid) seen = 1'b1;
    end
    chk1("flush_new_seen", seen, 1'b1);
    chk("flush_new_pc", id_pc, 32'h100);
    chk("flush_new_inst", id_inst, 32'hDEAD_BEEF);
    drain();

    // Flush colliding with a response and a pop, three outstanding
    cyc(); id_ready = 1'b0;
    send_pc(32'h40);
    cyc(); pc_valid = 1'b0;
    @(negedge clk); resp_pct = 0;
    send_pc(32'h44); send_pc(32'h48); send_pc(32'h4C);
    cyc(); pc_valid = 1'b0;
    @(negedge clk); resp_pct = 100;
    cyc(); flush = 1'b1; id_ready = 1'b1;
    cyc(); flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("collide_quiet", id_valid, 1'b0);
    end
    send_pc(32'h200);
    drain();

    // Reset with two outstanding; the late responses must be ignored
    cyc(); id_ready = 1'b1;
    @(negedge clk); resp_pct = 0;
    send_pc(32'h300); send_pc(32'h304);
    cyc(); pc_valid = 1'b0; rst = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk); resp_pct = 100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("spurious_id_valid", id_valid, 1'b0);
    end
    chk("spurious_id_pc", id_pc, 32'h0);
    drain();

    // Random traffic with occasional flushes
    @(negedge clk); resp_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      pc_valid       = ($urandom_range(0, 99) < 70);
      pc_in          = $urandom & 32'hFFFF_FFFC;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 99) < 60);
      flush          = ($urandom_range(0, 99) < 4);
    end
    cyc(); flush = 1'b0; imem_req_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
